waterfall_scroller: RTL

Parametrised scrolling frame-buffer controller for the waterfall display. It owns the single-port 8b-per-pixel frame buffer and clears it after reset. During active video it generates pipelined read addresses. In lower blanking it copies one line of bins from the frequency BRAM into a ring-buffered row. Row count, width, scroll rate, scroll direction and freeze are parametrised or runtime-selectable.

---
 rtl/waterfall_pkg.sv | 15 +
 rtl/waterfall_row_map.sv | 51 +++++
 rtl/waterfall_scroller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/waterfall_pkg.sv
// Shared types and constants for the waterfall frame-buffer controller.
package waterfall_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    VIDEO,
    WRITE_LINE,
    WAIT_BLANK_END
  } state_t;

  localparam int DEF_H_RES     = 320;
  localparam int DEF_V_RES     = 240;
  localparam int READ_PIPE_LAT = 3;

endpackage

// File: rtl/waterfall_row_map.sv
// Ring-row mapping plus registered row*H_RES+x address stage (2-cycle latency).
module waterfall_row_map
  import waterfall_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int FB_AW = 17,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROW_W-1:0] w_row,
  input  logic [7:0]       y,
  input  logic [8:0]       x,
  input  logic             dir,
  output logic [FB_AW-1:0] addr
);

  logic [10:0]      w_ext;
  logic [10:0]      y_ext;
  logic [10:0]      fwd;
  logic [10:0]      row_sel;
  logic [ROW_W-1:0] row_reg;
  logic [8:0]       x_reg;

  assign w_ext = 11'(w_row);
  assign y_ext = 11'(y);
  assign fwd   = w_ext + y_ext + 11'd1;

  // One conditional add/subtract of V_RES is enough because y never exceeds the ring depth.
  always_comb begin
    row_sel = '0;
    if (dir)
      row_sel = (fwd >= 11'(V_RES)) ? fwd - 11'(V_RES) : fwd;
    else
      row_sel = (w_ext >= y_ext) ? w_ext - y_ext : w_ext + 11'(V_RES) - y_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_reg <= '0;
      x_reg   <= '0;
      addr    <= '0;
    end else begin
      row_reg <= ROW_W'(row_sel);
      x_reg   <= x;
      addr    <= FB_AW'(row_reg) * FB_AW'(H_RES) + FB_AW'(x_reg);
    end
  end

endmodule

// File: rtl/waterfall_scroller.sv
// Scrolling waterfall frame-buffer controller: post-reset clear, display read
// addressing and one-line-per-blank ring writes. Optional marker lines: WATERFALL_MARK_EN.
module waterfall_scroller
  import waterfall_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int PIX_W       = 8,
  parameter int FB_AW       = 17,
  parameter int DIV_W       = 4,
  parameter int MARK_PERIOD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       x,
  input  logic [7:0]       y,
  input  logic             lower_blank,
  input  logic [DIV_W-1:0] scroll_div,
  input  logic             scroll_dir,
  input  logic             freeze,
  output logic [8:0]       bin_raddr,
  output logic             bin_re,
  input  logic [PIX_W-1:0] bin_rdata,
  output logic [FB_AW-1:0] fb_addr,
  output logic [PIX_W-1:0] fb_wdata,
  output logic             fb_we,
  output logic             pix_blank,
  output logic             clearing,
  output logic             line_done
);

  localparam int ROW_W    = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int CNT_W    = $clog2(H_RES + 2);
  localparam int FB_WORDS = H_RES * V_RES;

  if (FB_AW < $clog2(FB_WORDS)) begin : g_fb_aw_check
    $error("FB_AW too narrow for H_RES*V_RES");
  end
  if (MARK_PERIOD < 1) begin : g_mark_check
    $error("MARK_PERIOD must be at least 1");
  end

  state_t                   state_reg;
  logic [ROW_W-1:0]         w_row_reg;
  logic [ROW_W-1:0]         nw_row;
  logic [DIV_W-1:0]         frame_cnt_reg;
  logic [CNT_W-1:0]         wr_cnt_reg;
  logic [FB_AW-1:0]         clr_addr_reg;
  logic [FB_AW-1:0]         map_addr;
  logic                     fb_we_reg;
  logic                     clearing_reg;
  logic                     bin_re_reg;
  logic [8:0]               bin_raddr_reg;
  logic                     line_done_reg;
  logic [READ_PIPE_LAT-1:0] blank_pipe_reg;
  logic                     in_write;
  logic                     line_end;
  logic                     mark_hit;

  assign nw_row   = (w_row_reg == ROW_W'(V_RES - 1)) ? '0 : w_row_reg + 1'b1;
  assign in_write = (state_reg == WRITE_LINE);
  assign line_end = in_write && (wr_cnt_reg == CNT_W'(H_RES + 1));

  // While writing, the mapper is steered to row nw so it produces the write address.
  waterfall_row_map #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .FB_AW (FB_AW),
    .ROW_W (ROW_W)
  ) u_row_map (
    .clk   (clk),
    .reset (reset),
    .w_row (in_write ? nw_row : w_row_reg),
    .y     (in_write ? 8'd0 : y),
    .x     (in_write ? 9'(wr_cnt_reg) : x),
    .dir   (in_write ? 1'b0 : scroll_dir),
    .addr  (map_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= CLEAR;
      w_row_reg     <= '0;
      frame_cnt_reg <= '0;
      wr_cnt_reg    <= '0;
      clr_addr_reg  <= '0;
      fb_we_reg     <= 1'b0;
      clearing_reg  <= 1'b1;
      bin_re_reg    <= 1'b0;
      bin_raddr_reg <= '0;
      line_done_reg <= 1'b0;
    end else begin
      line_done_reg <= 1'b0;
      case (state_reg)
        CLEAR: begin
          fb_we_reg <= 1'b1;
          if (fb_we_reg) begin
            clr_addr_reg <= clr_addr_reg + 1'b1;
            if (clr_addr_reg == FB_AW'(FB_WORDS - 2))
              state_reg <= VIDEO;
          end
        end
        VIDEO: begin
          fb_we_reg    <= 1'b0;
          clearing_reg <= 1'b0;
          if (lower_blank) begin
            if (!freeze && frame_cnt_reg == scroll_div) begin
              frame_cnt_reg <= '0;
              wr_cnt_reg    <= '0;
              state_reg     <= WRITE_LINE;
            end else begin
              if (!freeze)
                frame_cnt_reg <= (frame_cnt_reg >= scroll_div) ? scroll_div
                                                                : frame_cnt_reg + 1'b1;
              state_reg <= WAIT_BLANK_END;
            end
          end
        end
        WRITE_LINE: begin
          // Write strobe trails the bin read by one cycle, matching BRAM latency.
          fb_we_reg <= bin_re_reg;
          if (wr_cnt_reg < CNT_W'(H_RES)) begin
            bin_re_reg    <= 1'b1;
            bin_raddr_reg <= 9'(wr_cnt_reg);
            wr_cnt_reg    <= wr_cnt_reg + 1'b1;
          end else if (!line_end) begin
            bin_re_reg <= 1'b0;
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
          end else begin
            w_row_reg     <= nw_row;
            line_done_reg <= 1'b1;
            state_reg     <= WAIT_BLANK_END;
          end
        end
        WAIT_BLANK_END: begin
          fb_we_reg <= 1'b0;
          if (!lower_blank)
            state_reg <= VIDEO;
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      blank_pipe_reg <= '0;
    else
      blank_pipe_reg <= {blank_pipe_reg[READ_PIPE_LAT-2:0], (x < 9'(READ_PIPE_LAT))};
  end

`ifdef WATERFALL_MARK_EN
  localparam int MARK_W = (MARK_PERIOD > 1) ? $clog2(MARK_PERIOD) : 1;
  logic [MARK_W-1:0] mark_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      mark_cnt_reg <= '0;
    else if (line_end)
      mark_cnt_reg <= (mark_cnt_reg == MARK_W'(MARK_PERIOD - 1)) ? '0 : mark_cnt_reg + 1'b1;
  end

  assign mark_hit = (mark_cnt_reg == MARK_W'(MARK_PERIOD - 1));
`else
  assign mark_hit = 1'b0;
`endif

  assign fb_addr   = clearing_reg ? clr_addr_reg : map_addr;
  assign fb_wdata  = (fb_we_reg && !clearing_reg) ? (mark_hit ? '1 : bin_rdata) : '0;
  assign fb_we     = fb_we_reg;
  assign clearing  = clearing_reg;
  assign bin_re    = bin_re_reg;
  assign bin_raddr = bin_raddr_reg;
  assign line_done = line_done_reg;
  assign pix_blank = blank_pipe_reg[READ_PIPE_LAT-1];

endmodule
